// File: rtl/tile_paint_arbiter_if.sv
// Tile-paint bus: two requesters' paint requests and the shared VGA pixel-write port.
// master = requester side, slave = the arbiter that owns the pixel port.
interface tile_paint_arbiter_if;
  logic [1:0] req;
  logic [1:0] tile0;
  logic [1:0] tile1;
  logic       flash0;
  logic       flash1;
  logic [1:0] gnt;
  logic [1:0] done;
  logic       busy;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;

  modport master (
    output req, tile0, tile1, flash0, flash1,
    input  gnt, done, busy, x, y, colour, plot
  );

  modport slave (
    input  req, tile0, tile1, flash0, flash1,
    output gnt, done, busy, x, y, colour, plot
  );
endinterface

// File: rtl/tile_paint_arbiter.sv
// Shares the VGA pixel-write port between two 8x8 tile-paint requesters.
// Optional macro TILE_PAINT_RR_EN: round-robin arbitration (default: requester 0 has fixed priority).
//
// state        | meaning
// IDLE         | waiting for a request, winner chosen here
// LOAD         | gnt to winner, latch tile, clear counters
// DRAW_FLASH   | 64 pixel writes in FLASH_COLOUR
// HOLD         | plot low for HOLD_CYCLES clocks
// DRAW_NORMAL  | 64 pixel writes in the tile's palette colour
// DONE         | done pulse to the granted requester
module tile_paint_arbiter #(
  parameter logic [7:0]  X0           = 8'd40,
  parameter logic [6:0]  Y0           = 7'd20,
  parameter logic [7:0]  PITCH        = 8'd40,
  parameter logic [25:0] HOLD_CYCLES  = 26'd25_000_000,
  parameter logic [2:0]  FLASH_COLOUR = 3'b111
) (
  input logic clock,
  input logic reset,
  tile_paint_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DRAW_FLASH, S_HOLD, S_DRAW_NORMAL, S_DONE
  } state_t;

  localparam logic [6:0]  PITCH_Y   = PITCH[6:0];
  localparam logic [25:0] HOLD_LAST = HOLD_CYCLES - 26'd1;

  state_t      state;
  logic        id;
  logic [1:0]  tile;
  logic [5:0]  pix;
  logic [25:0] hold_cnt;
  logic        win_id;
  logic        sel_flash;
  logic        drawing;
  logic [7:0]  ox;
  logic [6:0]  oy;
  logic [2:0]  palette;

`ifdef TILE_PAINT_RR_EN
  logic last;

  always_comb begin
    win_id = 1'b0;
    if (bus.req == 2'b11) win_id = ~last;
    else                  win_id = bus.req[1];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                 last <= 1'b1;
    else if (state == S_LOAD)  last <= id;
  end
`else
  always_comb begin
    win_id = 1'b0;
    if (!bus.req[0]) win_id = bus.req[1];
  end
`endif

  assign sel_flash = id ? bus.flash1 : bus.flash0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      id       <= 1'b0;
      tile     <= 2'd0;
      pix      <= 6'd0;
      hold_cnt <= 26'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|bus.req) begin
            id    <= win_id;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          tile     <= id ? bus.tile1 : bus.tile0;
          pix      <= 6'd0;
          hold_cnt <= 26'd0;
          state    <= sel_flash ? S_DRAW_FLASH : S_DRAW_NORMAL;
        end
        S_DRAW_FLASH: begin
          pix <= pix + 6'd1;
          if (pix == 6'd63) state <= S_HOLD;
        end
        S_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt <= 26'd0;
            state    <= S_DRAW_NORMAL;
          end else begin
            hold_cnt <= hold_cnt + 26'd1;
          end
        end
        S_DRAW_NORMAL: begin
          pix <= pix + 6'd1;
          if (pix == 6'd63) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    palette = 3'b100;
    case (tile)
      2'd0: palette = 3'b100;
      2'd1: palette = 3'b010;
      2'd2: palette = 3'b001;
      2'd3: palette = 3'b110;
      default: palette = 3'b100;
    endcase
  end

  // Moore outputs: reset drives state to IDLE asynchronously, so plot drops at once.
  assign drawing = (state == S_DRAW_FLASH) || (state == S_DRAW_NORMAL);
  assign ox      = X0 + (tile[0] ? PITCH : 8'd0);
  assign oy      = Y0 + (tile[1] ? PITCH_Y : 7'd0);

  assign bus.plot   = drawing;
  assign bus.x      = drawing ? ox + {5'd0, pix[2:0]} : 8'd0;
  assign bus.y      = drawing ? oy + {4'd0, pix[5:3]} : 7'd0;
  assign bus.colour = (state == S_DRAW_FLASH)  ? FLASH_COLOUR :
                      (state == S_DRAW_NORMAL) ? palette : 3'd0;
  assign bus.busy   = (state != S_IDLE);
  assign bus.gnt    = (state == S_LOAD) ? (id ? 2'b10 : 2'b01) : 2'b00;
  assign bus.done   = (state == S_DONE) ? (id ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_tile_paint_arbiter.sv
// Scoreboard bench for tile_paint_arbiter: expected pixels, grants and dones are queued at stimulus time.
// Contention expectations follow TILE_PAINT_RR_EN when it is defined for the build.
module tb_tile_paint_arbiter;
  logic clock;
  logic reset;
  int   errors;
  int   checks;
  int   cyc;

  tile_paint_arbiter_if bus();

  tile_paint_arbiter #(.HOLD_CYCLES(26'd5)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  logic [17:0] pix_q[$];
  logic [1:0]  gnt_q[$];
  logic [1:0]  done_q[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_tile(input logic [1:0] t, input logic [2:0] c);
    int ox;
    int oy;
    ox = 40 + (t[0] ? 40 : 0);
    oy = 20 + (t[1] ? 40 : 0);
    for (int p = 0; p < 64; p++)
      pix_q.push_back({8'(ox + p % 8), 7'(oy + p / 8), c});
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (bus.plot) begin
        if (pix_q.size() == 0) check("pix_extra", {14'd0, bus.x, bus.y, bus.colour}, 32'd0);
        else                   check("pixel", {14'd0, bus.x, bus.y, bus.colour}, {14'd0, pix_q.pop_front()});
      end else if (bus.busy) begin
        check("xyc_zero", {14'd0, bus.x, bus.y, bus.colour}, 32'd0);
      end
      if (bus.gnt != 2'b00) begin
        if (gnt_q.size() == 0) check("gnt_extra", {30'd0, bus.gnt}, 32'd0);
        else                   check("gnt_order", {30'd0, bus.gnt}, {30'd0, gnt_q.pop_front()});
      end
      if (bus.done != 2'b00) begin
        if (done_q.size() == 0) check("done_extra", {30'd0, bus.done}, 32'd0);
        else                    check("done_order", {30'd0, bus.done}, {30'd0, done_q.pop_front()});
      end
    end
  end

  task automatic wait_gnt(input logic [1:0] g, output int c);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (bus.gnt != g && n < 300);
    check("gnt_seen", {30'd0, bus.gnt}, {30'd0, g});
    c = cyc;
  endtask

  task automatic wait_done(input logic [1:0] g, output int c, output int quiet);
    int n;
    n = 0;
    quiet = 0;
    do begin
      @(negedge clock);
      n++;
      if (bus.busy && !bus.plot && bus.done == 2'b00 && bus.gnt == 2'b00) quiet++;
    end while (bus.done != g && n < 400);
    check("done_seen", {30'd0, bus.done}, {30'd0, g});
    c = cyc;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int req_c, gnt_c, done_c, quiet;
    logic [1:0] exp_g;
    errors = 0;
    checks = 0;
    cyc    = 0;
    reset  = 1'b1;
    bus.req = 2'b00;
    bus.tile0 = 2'd0;
    bus.tile1 = 2'd0;
    bus.flash0 = 1'b0;
    bus.flash1 = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_plot", {31'd0, bus.plot}, 32'd0);
    check("rst_gnt_done", {28'd0, bus.gnt, bus.done}, 32'd0);
    check("rst_xyc", {14'd0, bus.x, bus.y, bus.colour}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // plain paint, tile 2, requester 0
    push_tile(2'd2, 3'b001);
    gnt_q.push_back(2'b01);
    done_q.push_back(2'b01);
    bus.tile0 = 2'd2;
    bus.flash0 = 1'b0;
    bus.req = 2'b01;
    req_c = cyc;
    wait_gnt(2'b01, gnt_c);
    bus.req = 2'b00;
    check("req_to_load", 32'(gnt_c - req_c), 32'd1);
    @(negedge clock);
    check("first_plot", {31'd0, bus.plot}, 32'd1);
    wait_done(2'b01, done_c, quiet);
    check("plain_len", 32'(done_c - gnt_c + 1), 32'd66);
    check("plain_quiet", 32'(quiet), 32'd0);
    @(negedge clock);
    check("plain_idle", {31'd0, bus.busy}, 32'd0);

    // flash paint, tile 1, requester 1, HOLD_CYCLES = 5
    push_tile(2'd1, 3'b111);
    push_tile(2'd1, 3'b010);
    gnt_q.push_back(2'b10);
    done_q.push_back(2'b10);
    bus.tile1 = 2'd1;
    bus.flash1 = 1'b1;
    bus.req = 2'b10;
    wait_gnt(2'b10, gnt_c);
    bus.req = 2'b00;
    wait_done(2'b10, done_c, quiet);
    check("flash_len", 32'(done_c - gnt_c + 1), 32'd135);
    check("flash_hold", 32'(quiet), 32'd5);
    @(negedge clock);

    // contention with both requests held through three paints
    bus.tile0 = 2'd0;
    bus.flash0 = 1'b0;
    bus.tile1 = 2'd3;
    bus.flash1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
`ifdef TILE_PAINT_RR_EN
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_g = 2'b01;
`endif
      if (exp_g == 2'b01) push_tile(2'd0, 3'b100);
      else                push_tile(2'd3, 3'b110);
      gnt_q.push_back(exp_g);
      done_q.push_back(exp_g);
    end
    bus.req = 2'b11;
    for (int i = 0; i < 3; i++) begin
`ifdef TILE_PAINT_RR_EN
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_g = 2'b01;
`endif
      wait_gnt(exp_g, gnt_c);
      wait_done(exp_g, done_c, quiet);
      if (i == 2) bus.req = 2'b00;
      @(negedge clock);
      check("contend_gap", {31'd0, bus.busy}, 32'd0);
    end

    // request from requester 1 while requester 0 is drawing
    push_tile(2'd3, 3'b110);
    push_tile(2'd0, 3'b100);
    gnt_q.push_back(2'b01);
    gnt_q.push_back(2'b10);
    done_q.push_back(2'b01);
    done_q.push_back(2'b10);
    bus.tile0 = 2'd3;
    bus.req = 2'b01;
    wait_gnt(2'b01, gnt_c);
    bus.req = 2'b00;
    repeat (10) @(negedge clock);
    bus.tile1 = 2'd0;
    bus.flash1 = 1'b0;
    bus.req = 2'b10;
    wait_done(2'b01, done_c, quiet);
    @(negedge clock);
    check("busy_req_idle", {29'd0, bus.busy, bus.gnt}, 32'd0);
    wait_gnt(2'b10, gnt_c);
    bus.req = 2'b00;
    check("busy_req_delay", 32'(gnt_c - done_c), 32'd2);
    wait_done(2'b10, done_c, quiet);
    @(negedge clock);

    // reset at pix 30 of DRAW_FLASH
    for (int p = 0; p < 30; p++)
      pix_q.push_back({8'(40 + p % 8), 7'(20 + p / 8), 3'b111});
    gnt_q.push_back(2'b01);
    bus.tile0 = 2'd0;
    bus.flash0 = 1'b1;
    bus.req = 2'b01;
    wait_gnt(2'b01, gnt_c);
    bus.req = 2'b00;
    repeat (31) @(posedge clock);
    #1;
    check("pre_abort_plot", {31'd0, bus.plot}, 32'd1);
    reset = 1'b1;
    #1;
    check("abort_plot", {31'd0, bus.plot}, 32'd0);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_pix_left", 32'(pix_q.size()), 32'd0);
    repeat (2) @(negedge clock);
    check("abort_no_done", {30'd0, bus.done}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    push_tile(2'd0, 3'b100);
    gnt_q.push_back(2'b01);
    done_q.push_back(2'b01);
    bus.flash0 = 1'b0;
    bus.req = 2'b01;
    wait_gnt(2'b01, gnt_c);
    bus.req = 2'b00;
    wait_done(2'b01, done_c, quiet);
    check("restart_len", 32'(done_c - gnt_c + 1), 32'd66);
    repeat (3) @(negedge clock);

    check("end_pix_q", 32'(pix_q.size()), 32'd0);
    check("end_gnt_q", 32'(gnt_q.size()), 32'd0);
    check("end_done_q", 32'(done_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
